// File: rtl/qar_pkg.sv
// Shared types and defaults for the QAR-Core integer register file.
package qar_pkg;

    localparam int QAR_XLEN  = 32;
    localparam int QAR_DEPTH = 32;
    localparam int REG_AW    = $clog2(QAR_DEPTH);

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback,
// flushed in one edge when a context clear starts. x0 is never busy.
module rf_scoreboard #(
    parameter int DEPTH = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              set_vld,
    input  logic [AW-1:0]     set_rd,
    input  logic [NWR-1:0]    clr_en,
    input  logic [NWR*AW-1:0] clr_addr,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Next busy vector: writeback clears, issue set overrides, flush overrides all.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NWR; k++) begin
            if (clr_en[k]) busy_nxt[clr_addr[k*AW +: AW]] = 1'b0;
        end
        if (set_vld && (set_rd != '0)) busy_nxt[set_rd] = 1'b1;
        if (flush) busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    // Busy bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // Lookup ports; busy[0] is held at zero so x0 reads as not busy.
    always_comb begin
        rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            rbusy[j] = busy[raddr[j*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard and sequential
// clear engine. Optional write-to-read forwarding under REGFILE_BYPASS_EN.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  RF_IDLE  | normal operation: writes, issue and clr_req are accepted
//  RF_CLEAR | zeroing regs[cnt] one per cycle, cnt = 1 .. DEPTH-1
module regfile_mp
    import qar_pkg::*;
#(
    parameter int XLEN  = QAR_XLEN,
    parameter int DEPTH = QAR_DEPTH,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                issue_vld,
    input  logic [AW-1:0]       issue_rd,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    localparam logic [AW-1:0] CNT_FIRST = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = AW'(DEPTH - 1);

    rf_state_t       state;
    rf_state_t       state_nxt;
    logic [AW-1:0]   cnt;
    logic            flush;
    logic [NWR-1:0]  wr_en;
    logic [NRD-1:0]  sb_rbusy;
    logic [XLEN-1:0] regs [DEPTH];

    // Effective write enables: dropped for x0 and while clearing.
    always_comb begin
        wr_en = '0;
        for (int k = 0; k < NWR; k++) begin
            wr_en[k] = we[k] && (waddr[k*AW +: AW] != '0) && (state == RF_IDLE);
        end
    end

    // Clear FSM next-state and status outputs.
    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt = RF_CLEAR;
                    flush     = 1'b1;
                end
            end
            RF_CLEAR: begin
                clr_busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    clr_done  = 1'b1;
                    state_nxt = RF_IDLE;
                end
            end
            default: state_nxt = RF_IDLE;
        endcase
    end

    // FSM state and clear pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (flush)                  cnt <= CNT_FIRST;
            else if (state == RF_CLEAR) cnt <= cnt + 1'b1;
        end
    end

    // Register array: clear engine or prioritised writes (later port wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (state == RF_CLEAR) begin
            regs[cnt] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k]) regs[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
            end
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .set_vld  (issue_vld && (state == RF_IDLE)),
        .set_rd   (issue_rd),
        .clr_en   (wr_en),
        .clr_addr (waddr),
        .raddr    (raddr),
        .rbusy    (sb_rbusy)
    );

    // Read ports; x0 reads zero, optional forwarding from this cycle's writes.
    always_comb begin
        rdata = '0;
        rbusy = sb_rbusy;
        for (int j = 0; j < NRD; j++) begin
            if (raddr[j*AW +: AW] != '0) rdata[j*XLEN +: XLEN] = regs[raddr[j*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (waddr[k*AW +: AW] == raddr[j*AW +: AW])) begin
                    rdata[j*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
                    rbusy[j]              = 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against a behavioural array model.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                issue_vld;
    logic [AW-1:0]       issue_rd;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;

    int n_vec = 0;
    int n_err = 0;

    logic [XLEN-1:0] m_regs [DEPTH];
    bit              m_busy [DEPTH];
    int              m_clr_left;
    logic            obs_busy;
    logic            obs_done;

    regfile_mp #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .issue_vld (issue_vld),
        .issue_rd  (issue_rd),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input int j);
        int a;
        logic [XLEN-1:0] v;
        a = int'(raddr[j*AW +: AW]);
        if (a == 0) return '0;
        v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (m_clr_left == 0)
            for (int k = 0; k < NWR; k++)
                if (we[k] && int'(waddr[k*AW +: AW]) == a) v = wdata[k*XLEN +: XLEN];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input int j);
        int a;
        logic b;
        a = int'(raddr[j*AW +: AW]);
        if (a == 0) return 1'b0;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (m_clr_left == 0)
            for (int k = 0; k < NWR; k++)
                if (we[k] && int'(waddr[k*AW +: AW]) == a) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_clr_left = 0;
    endtask

    task automatic model_update();
        int a;
        if (m_clr_left > 0) begin
            m_regs[DEPTH - m_clr_left] = '0;
            m_clr_left--;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                a = int'(waddr[k*AW +: AW]);
                if (we[k] && a != 0) m_regs[a] = wdata[k*XLEN +: XLEN];
            end
            if (clr_req) begin
                m_clr_left = DEPTH - 1;
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            end else begin
                for (int k = 0; k < NWR; k++) begin
                    a = int'(waddr[k*AW +: AW]);
                    if (we[k] && a != 0) m_busy[a] = 1'b0;
                end
                if (issue_vld && issue_rd != '0) m_busy[issue_rd] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        for (int j = 0; j < NRD; j++) begin
            check($sformatf("rdata%0d[a=%0d]", j, raddr[j*AW +: AW]), 64'(rdata[j*XLEN +: XLEN]), 64'(exp_rd(j)));
            check($sformatf("rbusy%0d[a=%0d]", j, raddr[j*AW +: AW]), 64'(rbusy[j]), 64'(exp_busy(j)));
        end
        check("clr_busy", 64'(clr_busy), 64'(m_clr_left > 0));
        check("clr_done", 64'(clr_done), 64'(m_clr_left == 1));
        obs_busy = clr_busy;
        obs_done = clr_done;
    endtask

    // One clock: check at negedge, advance the model at posedge, return at posedge+1.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_idle();
        we        = '0;
        waddr     = '0;
        wdata     = '0;
        issue_vld = 1'b0;
        issue_rd  = '0;
        clr_req   = 1'b0;
    endtask

    task automatic wr(input int port, input int a, input logic [XLEN-1:0] d);
        we[port]                = 1'b1;
        waddr[port*AW +: AW]    = AW'(a);
        wdata[port*XLEN +: XLEN] = d;
    endtask

    task automatic set_raddr(input int r0, input int r1);
        raddr[0 +: AW]  = AW'(r0);
        raddr[AW +: AW] = AW'(r1);
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int busy_cycles;
        int done_at;
        rst_n = 1'b0;
        drive_idle();
        set_raddr(3, 17);
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write, then read back on port 0 with port 1 on x0.
        wr(0, 5, 32'hDEAD_BEEF);
        cycle();
        drive_idle();
        set_raddr(5, 0);
        #2;
        check("t1_x5", 64'(rdata[31:0]), 64'h0000_0000_DEAD_BEEF);
        check("t1_x0", 64'(rdata[63:32]), 64'h0);
        cycle();

        // Same-address conflict and x0 discard.
        wr(0, 7, 32'h0000_1111);
        wr(1, 7, 32'h0000_2222);
        cycle();
        drive_idle();
        wr(0, 0, 32'hFFFF_FFFF);
        set_raddr(7, 0);
        #2;
        check("t2_x7", 64'(rdata[31:0]), 64'h2222);
        cycle();
        drive_idle();
        #2;
        check("t2_x0", 64'(rdata[63:32]), 64'h0);
        cycle();

        // Scoreboard: set wins over same-cycle clear.
        issue_vld = 1'b1;
        issue_rd  = 5'd9;
        set_raddr(0, 0);
        cycle();
        drive_idle();
        wr(0, 9, 32'h0000_0123);
        issue_vld = 1'b1;
        issue_rd  = 5'd9;
        cycle();
        drive_idle();
        set_raddr(9, 0);
        #2;
        check("t3_busy_set_wins", 64'(rbusy[0]), 64'h1);
        cycle();
        set_raddr(0, 0);
        wr(1, 9, 32'h0000_0456);
        cycle();
        drive_idle();
        set_raddr(9, 9);
        #2;
        check("t3_busy_cleared", 64'(rbusy[1]), 64'h0);
        cycle();

        // Forwarding versus pre-edge value.
        wr(0, 3, 32'h1234_5678);
        set_raddr(0, 0);
        cycle();
        drive_idle();
        wr(0, 3, 32'hA5A5_A5A5);
        set_raddr(3, 0);
        #2;
`ifdef REGFILE_BYPASS_EN
        check("t4_bypass", 64'(rdata[31:0]), 64'hA5A5_A5A5);
`else
        check("t4_nobypass", 64'(rdata[31:0]), 64'h1234_5678);
`endif
        cycle();
        drive_idle();

        // Fill x1..x31, clear, drop a write mid-clear.
        for (int i = 1; i < DEPTH; i += 2) begin
            drive_idle();
            wr(0, i, $urandom | 32'h1);
            if (i + 1 < DEPTH) wr(1, i + 1, $urandom | 32'h1);
            issue_vld = 1'b1;
            issue_rd  = AW'($urandom_range(1, DEPTH - 1));
            set_raddr($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            cycle();
        end
        drive_idle();
        clr_req = 1'b1;
        cycle();
        drive_idle();
        busy_cycles = 0;
        done_at     = 0;
        for (int t = 1; t <= 40; t++) begin
            drive_idle();
            set_raddr($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            if (t == 5) begin
                wr(0, 1, 32'hFFFF_FFFF);
                wr(1, 31, 32'hFFFF_FFFF);
                issue_vld = 1'b1;
                issue_rd  = 5'd4;
                clr_req   = 1'b1;
            end
            cycle();
            if (obs_busy) busy_cycles++;
            if (obs_done) done_at = t;
            if (!obs_busy && busy_cycles > 0) break;
        end
        drive_idle();
        check("t5_busy_cycles", 64'(busy_cycles), 64'd31);
        check("t5_done_cycle", 64'(done_at), 64'd31);
        for (int a = 0; a < DEPTH; a += 2) begin
            set_raddr(a, a + 1);
            #2;
            check($sformatf("t5_zero_x%0d", a), 64'(rdata[31:0]), 64'h0);
            check($sformatf("t5_zero_x%0d", a + 1), 64'(rdata[63:32]), 64'h0);
            check($sformatf("t5_idle_x%0d", a), 64'(rbusy), 64'h0);
            cycle();
        end

        // Reset during clear cycle 10.
        for (int i = 20; i < DEPTH; i++) begin
            drive_idle();
            wr(0, i, 32'hC0DE_0000 | 32'(i));
            cycle();
        end
        drive_idle();
        clr_req = 1'b1;
        cycle();
        drive_idle();
        for (int t = 1; t < 10; t++) cycle();
        set_raddr(25, 30);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_clr_busy_async", 64'(clr_busy), 64'h0);
        check("t6_x25", 64'(rdata[31:0]), 64'h0);
        check("t6_x30", 64'(rdata[63:32]), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        wr(0, 20, 32'h0BAD_F00D);
        cycle();
        drive_idle();
        set_raddr(20, 0);
        #2;
        check("t6_write_after", 64'(rdata[31:0]), 64'h0BAD_F00D);
        cycle();

        // Randomized traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            drive_idle();
            set_raddr($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 39) == 0) begin
                clr_req = 1'b1;
            end else begin
                for (int k = 0; k < NWR; k++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        if ($urandom_range(0, 3) == 0)
                            wr(k, int'(raddr[$urandom_range(0, NRD - 1)*AW +: AW]), $urandom);
                        else
                            wr(k, $urandom_range(0, DEPTH - 1), $urandom);
                    end
                end
                issue_vld = $urandom_range(0, 1) == 1;
                issue_rd  = AW'($urandom_range(0, DEPTH - 1));
            end
            cycle();
        end

        drive_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
